// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one outstanding instruction-memory
// request at a time, buffers the response and drives the IF/ID stall/flush controls.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_stall_ext,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_instr_if,
  output logic [31:0] o_pc_if,
  output logic [31:0] o_pc_plus4_if,
  output logic        o_stall_id,
  output logic        o_flush_id,
  output logic        o_fetch_err
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[7:0];

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic [31:0] r_buf_data;
  logic [31:0] r_buf_pc;
  logic        r_buf_valid;
  logic [7:0]  r_wait_cnt;
  logic        r_fetch_err;

  logic        w_hs;
  logic [31:0] w_redirect_pc;
  logic [7:0]  w_cnt_inc;
  logic        w_timeout_hit;

  assign o_imem_req_valid = (r_state == S_REQ) & ~reset;
  assign o_imem_addr      = r_pc;
  assign w_hs             = o_imem_req_valid & i_imem_req_ready;
  assign w_redirect_pc    = i_redirect_pc & ~32'h3;
  assign w_cnt_inc        = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;
  assign w_timeout_hit    = (w_cnt_inc == TIMEOUT_LIMIT);

  assign o_flush_id    = i_redirect_valid | (~r_buf_valid & ~i_stall_ext);
  assign o_stall_id    = i_stall_ext & ~i_redirect_valid;
  assign o_instr_if    = r_buf_valid ? r_buf_data : 32'h0;
  assign o_pc_if       = r_buf_valid ? r_buf_pc : 32'h0;
  assign o_pc_plus4_if = r_buf_valid ? r_buf_pc + 32'd4 : 32'h0;
  assign o_fetch_err   = r_fetch_err;

  // A redirect always wins; a request already accepted on the old path still owes a response (DROP).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_addr      <= 32'h0;
      r_buf_data  <= 32'h0;
      r_buf_pc    <= 32'h0;
      r_buf_valid <= 1'b0;
      r_wait_cnt  <= 8'h0;
      r_fetch_err <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          r_wait_cnt <= 8'h0;
          if (i_redirect_valid) begin
            r_pc <= w_redirect_pc;
            if (w_hs) r_state <= S_DROP;
          end else if (w_hs) begin
            r_addr  <= r_pc;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_imem_rsp_valid) begin
            r_wait_cnt <= 8'h0;
            if (i_redirect_valid) begin
              r_pc    <= w_redirect_pc;
              r_state <= S_REQ;
            end else begin
              r_buf_data  <= i_imem_rsp_data;
              r_buf_pc    <= r_addr;
              r_buf_valid <= 1'b1;
              r_state     <= S_HOLD;
            end
          end else begin
            r_wait_cnt <= w_cnt_inc;
            if (w_timeout_hit) r_fetch_err <= 1'b1;
            if (i_redirect_valid) begin
              r_pc    <= w_redirect_pc;
              r_state <= S_DROP;
            end
          end
        end
        S_HOLD: begin
          r_wait_cnt <= 8'h0;
          if (i_redirect_valid) begin
            r_pc        <= w_redirect_pc;
            r_buf_valid <= 1'b0;
            r_state     <= S_REQ;
          end else if (!i_stall_ext) begin
            r_pc        <= r_buf_pc + 32'd4;
            r_buf_valid <= 1'b0;
            r_state     <= S_REQ;
          end
        end
        S_DROP: begin
          if (i_redirect_valid) r_pc <= w_redirect_pc;
          if (i_imem_rsp_valid) begin
            r_wait_cnt <= 8'h0;
            r_state    <= S_REQ;
          end else begin
            r_wait_cnt <= w_cnt_inc;
            if (w_timeout_hit) r_fetch_err <= 1'b1;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed cycle-by-cycle stimulus with a scoreboard
// of expected request addresses and consumed instructions.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_stall_ext;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic [31:0] o_instr_if;
  logic [31:0] o_pc_if;
  logic [31:0] o_pc_plus4_if;
  logic        o_stall_id;
  logic        o_flush_id;
  logic        o_fetch_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } instrExp_t;

  logic [31:0] expAddrQ[$];
  instrExp_t   expInstrQ[$];

  always #5 clk = ~clk;

  if_fetch_ctrl #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_addr      (o_imem_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_stall_ext      (i_stall_ext),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_instr_if       (o_instr_if),
    .o_pc_if          (o_pc_if),
    .o_pc_plus4_if    (o_pc_plus4_if),
    .o_stall_id       (o_stall_id),
    .o_flush_id       (o_flush_id),
    .o_fetch_err      (o_fetch_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One call drives one clock cycle of inputs, settled just after the falling edge.
  task automatic applyStimulus(input logic ready, input logic rspV, input logic [31:0] rspD,
                               input logic stall, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    i_imem_req_ready = ready;
    i_imem_rsp_valid = rspV;
    i_imem_rsp_data  = rspD;
    i_stall_ext      = stall;
    i_redirect_valid = redir;
    i_redirect_pc    = rpc;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic expectInstr(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4);
    instrExp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.pc4   = pc4;
    expInstrQ.push_back(e);
  endtask

  // Monitor: every accepted request and every consumed instruction is matched against the queues.
  initial begin
    logic [31:0] a;
    instrExp_t   e;
    forever begin
      @(negedge clk);
      #2;
      if (o_imem_req_valid && i_imem_req_ready) begin
        if (expAddrQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL req_addr unexpected request actual=%h required=none", o_imem_addr);
        end else begin
          a = expAddrQ.pop_front();
          checkOutput("req_addr", o_imem_addr, a);
        end
      end
      if (!o_flush_id && !o_stall_id) begin
        if (expInstrQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL consume unexpected instr actual=%h required=none", o_instr_if);
        end else begin
          e = expInstrQ.pop_front();
          checkOutput("consume_instr", o_instr_if, e.instr);
          checkOutput("consume_pc", o_pc_if, e.pc);
          checkOutput("consume_pc4", o_pc_plus4_if, e.pc4);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset            = 1'b1;
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = 32'h0;
    i_stall_ext      = 1'b0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = 32'h0;

    @(negedge clk);
    #1;
    checkOutput("rst_req_valid", 32'(o_imem_req_valid), 32'd0);
    checkOutput("rst_flush", 32'(o_flush_id), 32'd1);
    checkOutput("rst_instr", o_instr_if, 32'h0);
    checkOutput("rst_fetch_err", 32'(o_fetch_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Zero-wait fetch of addr 0, then next request three cycles after the first accept
    expAddrQ.push_back(32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("first_req_valid", 32'(o_imem_req_valid), 32'd1);
    checkOutput("first_addr", o_imem_addr, 32'h0);
    checkOutput("bubble_flush", 32'(o_flush_id), 32'd1);
    expectInstr(32'h0000_0013, 32'h0, 32'h4);
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
    checkOutput("wait_req_valid", 32'(o_imem_req_valid), 32'd0);
    idleCycle();
    checkOutput("hold_instr", o_instr_if, 32'h0000_0013);
    checkOutput("hold_pc4", o_pc_plus4_if, 32'h4);
    expAddrQ.push_back(32'h4);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("second_addr", o_imem_addr, 32'h4);

    // Stall held for four cycles while an instruction is buffered
    expectInstr(32'h0010_0093, 32'h4, 32'h8);
    applyStimulus(1'b0, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("stall_stall_id", 32'(o_stall_id), 32'd1);
      checkOutput("stall_flush_id", 32'(o_flush_id), 32'd0);
      checkOutput("stall_instr", o_instr_if, 32'h0010_0093);
      checkOutput("stall_req_valid", 32'(o_imem_req_valid), 32'd0);
    end
    idleCycle();
    expAddrQ.push_back(32'h8);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("after_stall_addr", o_imem_addr, 32'h8);

    // Redirect while waiting; the late response must be dropped
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    checkOutput("redir_wait_flush", 32'(o_flush_id), 32'd1);
    checkOutput("redir_wait_stall", 32'(o_stall_id), 32'd0);
    idleCycle();
    checkOutput("drop_instr", o_instr_if, 32'h0);
    checkOutput("drop_req_valid", 32'(o_imem_req_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    checkOutput("drop_rsp_req_valid", 32'(o_imem_req_valid), 32'd0);
    expAddrQ.push_back(32'h100);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_addr_100", o_imem_addr, 32'h100);
    checkOutput("dropped_instr", o_instr_if, 32'h0);

    // Redirect coincident with the response
    applyStimulus(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h200);
    checkOutput("redir_rsp_flush", 32'(o_flush_id), 32'd1);
    expAddrQ.push_back(32'h200);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_addr_200", o_imem_addr, 32'h200);
    checkOutput("redir_rsp_instr", o_instr_if, 32'h0);

    // Redirect while holding: buffer discarded, low address bits cleared
    applyStimulus(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h303);
    checkOutput("redir_hold_flush", 32'(o_flush_id), 32'd1);

    // Memory not ready for three cycles
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("notready_req_valid", 32'(o_imem_req_valid), 32'd1);
      checkOutput("notready_addr", o_imem_addr, 32'h300);
      checkOutput("notready_flush", 32'(o_flush_id), 32'd1);
      checkOutput("notready_instr", o_instr_if, 32'h0);
    end
    checkOutput("pre_timeout_err", 32'(o_fetch_err), 32'd0);

    // Response withheld past the timeout; flag is sticky across a later response
    expAddrQ.push_back(32'h300);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      checkOutput("timeout_err_low", 32'(o_fetch_err), 32'd0);
    end
    idleCycle();
    checkOutput("timeout_err_high", 32'(o_fetch_err), 32'd1);
    expectInstr(32'h2222_2222, 32'h300, 32'h304);
    applyStimulus(1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0);
    idleCycle();
    checkOutput("err_sticky", 32'(o_fetch_err), 32'd1);
    expAddrQ.push_back(32'h304);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Reset with a request outstanding
    @(negedge clk);
    i_imem_req_ready = 1'b0;
    reset            = 1'b1;
    #1;
    checkOutput("midrst_err", 32'(o_fetch_err), 32'd0);
    checkOutput("midrst_req_valid", 32'(o_imem_req_valid), 32'd0);
    checkOutput("midrst_instr", o_instr_if, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0);
    idleCycle();
    checkOutput("stale_rsp_instr", o_instr_if, 32'h0);
    checkOutput("postrst_addr", o_imem_addr, 32'h0);
    checkOutput("postrst_req_valid", 32'(o_imem_req_valid), 32'd1);

    // PC wrap at the top of the address space
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    expAddrQ.push_back(32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    expectInstr(32'h4444_4444, 32'hFFFF_FFFC, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h4444_4444, 1'b0, 1'b0, 32'h0);
    idleCycle();
    checkOutput("wrap_pc4", o_pc_plus4_if, 32'h0);
    expAddrQ.push_back(32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr", o_imem_addr, 32'h0);
    expectInstr(32'h0000_0055, 32'h0, 32'h4);
    applyStimulus(1'b0, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 32'h0);
    idleCycle();
    idleCycle();
    idleCycle();

    checkOutput("addr_queue_empty", 32'(expAddrQ.size()), 32'd0);
    checkOutput("instr_queue_empty", 32'(expInstrQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Fetch-stage sequencer in front of the IF/ID pipeline register. Owns the program counter and issues single-outstanding requests to instruction memory over a valid/ready request and valid response handshake. Buffers each returned instruction, then presents it to IF/ID. Drives IF/ID stall_id/flush_id so that:
- wrong-path instructions are killed on a redirect;
- bubbles (all-zero instruction) are inserted while no fetched instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
TIMEOUT_CYCLES, 255, cycles a request may wait for a response before fetch_err is raised (8-bit counter, 1..255)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
imem_req_valid  output  1  request to instruction memory
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  32  request address (word aligned)
imem_rsp_valid  input  1  response data valid (one per accepted request)
imem_rsp_data  input  32  fetched instruction
stall_ext  input  1  downstream stall from hazard unit (ID cannot accept)
redirect_valid  input  1  branch/jump taken; redirect fetch
redirect_pc  input  32  redirect target
instr_if  output  32  instruction to IF/ID (0 when none)
pc_if  output  32  PC of instr_if
pc_plus4_if  output  32  pc_if + 4 (mod 2^32)
stall_id  output  1  IF/ID hold
flush_id  output  1  IF/ID clear (bubble)
fetch_err  output  1  sticky response-timeout flag

Behaviour:
- Reset values (async, immediate):
  - state=REQ, pc=RESET_PC, buf_valid=0, buf_data=0, buf_pc=0, wait_cnt=0, fetch_err=0.
  - imem_req_valid=1 is allowed in the first cycle after reset release. During reset it is 0.
- States:
  - REQ: imem_req_valid=1, imem_addr=pc. Handshake when valid&ready. On handshake → WAIT (addr latched).
  - WAIT: waiting for response. On rsp_valid: buf_data<=rsp_data, buf_pc<=latched addr, buf_valid<=1, → HOLD.
  - HOLD: buffered instruction offered. Consumed when stall_ext=0 and redirect_valid=0. On consume: buf_valid<=0, pc<=buf_pc+4, → REQ.
  - DROP: a response is owed but stale. On rsp_valid: discard the data, → REQ.
- Redirect (redirect_valid=1) takes priority over every other event; pc<=redirect_pc in all states.
  - REQ, no handshake that cycle: stay REQ. imem_addr shows the new pc next cycle. Memory tolerates an address change before acceptance.
  - REQ with handshake in the same cycle: → DROP.
  - WAIT without rsp_valid: → DROP.
  - WAIT with rsp_valid in the same cycle: response discarded, → REQ.
  - DROP: stay DROP unless rsp_valid, in which case → REQ.
  - HOLD: buf_valid<=0, → REQ.
- IF/ID control (combinational):
  - flush_id = redirect_valid | (~buf_valid & ~stall_ext).
  - stall_id = stall_ext & ~redirect_valid.
  - While stall_ext=1 with no valid buffer, the ID contents are held, not bubbled.
- Data outputs (combinational):
  - instr_if = buf_valid ? buf_data : 0.
  - pc_if = buf_valid ? buf_pc : 0.
  - pc_plus4_if = buf_valid ? buf_pc+4 : 0.
- Throughput with zero-wait memory (ready=1, rsp one cycle after accept): one instruction per 3 cycles. Sequence is REQ accept, rsp in WAIT, consume in HOLD. No request is overlapped.
- Exactly one request is outstanding; imem_req_valid=0 in WAIT, HOLD and DROP.
- PC arithmetic wraps modulo 2^32: FFFF_FFFC+4 = 0000_0000. The low 2 bits of redirect_pc are forced to 0.
- Timeout:
  - wait_cnt increments each cycle in WAIT or DROP and clears on leaving those states.
  - When wait_cnt reaches TIMEOUT_CYCLES, fetch_err<=1. It stays set until reset.
  - The state is unaffected; wait_cnt saturates.
- Reset asserted mid-operation: state returns to REQ at RESET_PC.
  - Any response that arrives after reset release and before the first new handshake is ignored.
  - Responses in REQ are never captured.

Test Plan:
- Reset release, ready=1, rsp one cycle after accept with data=0x00000013 for addr 0: instr_if=0x13, pc_if=0, pc_plus4_if=4 in HOLD. The next imem_addr is 0x4 three cycles after the first accept.
- stall_ext=1 for 4 cycles during HOLD: stall_id=1, flush_id=0, instr_if stable. No new request until stall_ext=0, then consumed and imem_addr=buf_pc+4.
- Redirect to 0x100 while in WAIT; the response 0xDEADBEEF arrives 2 cycles later: flush_id=1 in the redirect cycle, the response is discarded (instr_if stays 0), and the next imem_addr=0x100.
- Redirect to 0x200 in the same cycle as rsp_valid: data discarded, → REQ, next imem_addr=0x200. Redirect in HOLD: buffer dropped, flush_id=1.
- Memory with ready=0 for 3 cycles in REQ: imem_req_valid held 1, addr stable, flush_id=1 each cycle (bubbles).
- TIMEOUT_CYCLES=4, response withheld: fetch_err rises after 4 WAIT cycles and remains 1 after a later response. Reset clears it. Also check pc wrap from 0xFFFFFFFC to 0x0.
